// File: rtl/shift_add_mult_pkg.sv
// Shared types and sizing helpers for the shift-and-add multiplier.
package shift_add_mult_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // Controller states: waiting, iterating, result-valid pulse.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Iteration counter width; must be able to hold WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sam_step.sv
// One shift-and-add iteration: conditional add/subtract of the multiplicand
// into the accumulator, plus the bit that refills the accumulator MSB.
module sam_step #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] mcand,
  input  logic             mplr_lsb,
  input  logic             sgn,
  input  logic             last,
  output logic [WIDTH:0]   acc_sum_c,
  output logic             shift_in_c
);

  // Sum is one bit wider than ACC so its MSB is the true sign (signed) or carry (unsigned).
  localparam int unsigned SUM_W = WIDTH + 2;

  logic [SUM_W-1:0] acc_ext;
  logic [SUM_W-1:0] mcand_ext;
  logic [SUM_W-1:0] addend;
  logic [SUM_W-1:0] sum;

  // Extend operands per mode; the final signed step weights the multiplier MSB negatively.
  always_comb begin
    acc_ext    = sgn ? {acc[WIDTH], acc} : {1'b0, acc};
    mcand_ext  = sgn ? {{2{mcand[WIDTH-1]}}, mcand} : {2'b00, mcand};
    addend     = mplr_lsb ? mcand_ext : '0;
    sum        = (sgn && last) ? (acc_ext - addend) : (acc_ext + addend);
    acc_sum_c  = sum[WIDTH:0];
    shift_in_c = sum[SUM_W-1];
  end

endmodule

// File: rtl/shift_add_mult.sv
// Sequential WIDTH x WIDTH shift-and-add multiplier, unsigned or two's-complement
// per operation, with START/READY/BUSY/DONE handshake and a held product register.
module shift_add_mult
  import shift_add_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                          CK,
  input  logic                          RSTN,
  input  logic                          START,
  input  logic [WIDTH-1:0]              A,
  input  logic [WIDTH-1:0]              B,
  input  logic                          SGN,
  output logic [2*WIDTH-1:0]            P,
  output logic                          READY,
  output logic                          BUSY,
  output logic                          DONE,
  output logic [cnt_width(WIDTH)-1:0]   CNT
);

  localparam int unsigned       CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [WIDTH:0]       acc_q, acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplr_q, mplr_d;
  logic                 sgn_q, sgn_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 last_c;
  logic [WIDTH:0]       acc_sum_c;
  logic                 shift_in_c;

  assign last_c = (cnt_q == LAST_CNT);

  // Datapath for one iteration.
  sam_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc        (acc_q),
    .mcand      (mcand_q),
    .mplr_lsb   (mplr_q[0]),
    .sgn        (sgn_q),
    .last       (last_c),
    .acc_sum_c  (acc_sum_c),
    .shift_in_c (shift_in_c)
  );

  // Next-state, datapath update and registered output decode.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    sgn_d   = sgn_q;
    cnt_d   = cnt_q;
    p_d     = p_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          mcand_d = A;
          mplr_d  = B;
          sgn_d   = SGN;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // Shift {sum, MPLR} right by one, refilling the MSB with sign/carry.
        acc_d  = {shift_in_c, acc_sum_c[WIDTH:1]};
        mplr_d = {acc_sum_c[0], mplr_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_c) begin
          p_d     = {acc_sum_c, mplr_q[WIDTH-1:1]};
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d != S_RUN);
    busy_d  = (state_d == S_RUN);
    done_d  = (state_d == S_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      sgn_q   <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      sgn_q   <= sgn_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign P     = p_q;
  assign READY = ready_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign CNT   = cnt_q;

endmodule

// File: doc/shift_add_mult.md
# shift_add_mult

Parametrised sequential shift-and-add multiplier, successor to the fixed 4x4 START/READY multiplier. It multiplies two WIDTH-bit operands, unsigned or two's-complement selected per operation, over WIDTH iteration cycles. Handshake and results are registered. It sits between the operand source, which pulses START, and the product consumer, which samples P on DONE.

## Interface
- WIDTH, default 4: operand width in bits; legal values are 2..32.
- CK  in  1: clock, rising edge.
- RSTN  in  1: asynchronous active-low reset.
- START  in  1: request to start; A, B and SGN are sampled on the same edge.
- A  in  WIDTH: multiplicand.
- B  in  WIDTH: multiplier.
- SGN  in  1: 1 selects two's-complement operands and product; 0 selects unsigned.
- P  out  2*WIDTH: product register; holds its value until the next completion.
- READY  out  1: high in IDLE and DONE, meaning START will be accepted.
- BUSY  out  1: high in RUN.
- DONE  out  1: one-cycle pulse when P updates.
- CNT  out  $clog2(WIDTH+1): current iteration index, for observation.

## Operation
- Clock and reset: one clock, CK. RSTN is asynchronous and active-low.
- Reset values: state IDLE, P=0, READY=1, BUSY=0, DONE=0, CNT=0, all internal registers 0.
- States are IDLE, RUN and DONE.
  - IDLE, START=1: latch A into MCAND and B into MPLR, latch SGN, clear accumulator ACC (WIDTH+1 bits), set CNT=0, go to RUN.
  - RUN, each cycle:
    - If MPLR[0]=1, form ACC + ext(MCAND), where ext is sign-extension when SGN=1 and zero-extension when SGN=0.
    - In signed mode on the last iteration (CNT=WIDTH-1), subtract ext(MCAND) instead of adding.
    - Shift {ACC, MPLR} right by one. The bit shifted into the ACC MSB is the arithmetic sign of the sum in signed mode and the carry in unsigned mode.
    - Increment CNT. When CNT reaches WIDTH-1, go to DONE and load P with {ACC, MPLR} bits [2W-1:0].
  - DONE: DONE=1 and READY=1 for this one cycle. START=1 behaves as in IDLE (back-to-back). Otherwise go to IDLE.
- START in RUN is ignored: no restart, no latching, no error.
- Arithmetic: P equals A*B exactly in 2*WIDTH bits for every operand pair.
  - Unsigned worst case is (2^W-1)^2.
  - Signed worst case is (-2^(W-1))^2 = 2^(2W-2); it fits and no overflow is possible.
- Operand inputs may change freely after the accepting edge.

## Timing
- Edge e0 samples START=1 and enters RUN.
- Edges e1..eW perform the W iterations. Edge eW loads P and enters DONE.
- DONE is high and P is valid in the cycle after eW. Latency from the accepting edge is WIDTH+1 edges to DONE.
- Throughput is one product per WIDTH+1 cycles when START is held in DONE.
- P changes only at the completing edge and keeps its old value during RUN.
- BUSY=1 exactly during the WIDTH RUN cycles. READY is the complement of BUSY.
- Reset asserted mid-RUN immediately forces the reset values, including P=0. No DONE pulse follows.
- RSTN deassertion is expected to be synchronous to CK. The first START is accepted on the first edge with RSTN=1.

## Structure
- Package shift_add_mult_pkg holds:
  - typedef state_t {IDLE, RUN, DONE};
  - the CNT width, computed by a localparam function of WIDTH.
- Sub-module sam_step is purely combinational. It takes ACC, MCAND, MPLR[0], SGN and a last-iteration flag, and returns the next ACC and the shifted-in bit. It is parametrised by WIDTH.
- Top level contains the FSM, CNT, the ACC/MPLR/MCAND/P registers and the output decode.

## Test plan
- WIDTH=4, SGN=0, A=15, B=15, START for one cycle: BUSY high 4 cycles, then DONE pulse with P=8'hE1 (225); READY=1 after.
- WIDTH=4, SGN=1: A=4'b1000, B=4'b1000 gives P=8'h40 (64); A=4'hD, B=4'h5 gives P=8'hF1 (-15); A=4'h7, B=4'hF gives P=8'hF9 (-7).
- WIDTH=8, SGN=0, A=255, B=255 gives P=16'hFE01 after 9 edges. Sweep all 65536 pairs in both modes against a reference model.
- START re-pulsed with new operands on the 2nd RUN cycle: ignored, and the original product is delivered on schedule.
- START held high continuously: a DONE pulse every WIDTH+1 cycles, each with the correct product for the operands sampled in IDLE/DONE.
- RSTN low on the 3rd RUN cycle: P=0, READY=1, BUSY=0, and no DONE. The next START after release yields a correct product.
